in_channel_arbiter: RTL and testbench
=====================================

IN_CHANNEL_ARBITER -- requirements
Module: in_channel_arbiter

Interface
REQ-001 Parameter MemoryElementWidth, default 12, SHALL set the width of channel elements.
REQ-002 Parameter NIn, default 8, SHALL set the input channel depth (power of two not required).
REQ-003 Parameter NReq, default 2, SHALL set the number of requesters (2..8).
REQ-004 One clock; reset is asynchronous and active-high (ports clock and reset).
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 loadValid  input  1  producer offers loadData this cycle.
REQ-008 loadData  input  MemoryElementWidth  element to append to the channel.
REQ-009 loadReady  output  1  channel accepts a load this cycle.
REQ-010 req  input  NReq  per-requester request, held until granted.
REQ-011 op  input  NReq  per-requester operation: 0 = inSize, 1 = in.
REQ-012 grant  output  NReq  registered one-hot pulse naming the served requester.
REQ-013 data  output  MemoryElementWidth  registered response, valid while grant is non-zero.
REQ-014 hit  output  1  registered; 1 when a granted in removed an element.
REQ-015 count  output  clog2(NIn+1)  current number of stored elements.

Function
REQ-016 Storage: circular buffer of NIn elements with head and tail pointers, each wrapping from NIn-1 to 0.
REQ-017 loadReady SHALL equal (count < NIn) from registered state; a same-cycle pop SHALL NOT make a full channel ready.
REQ-018 On a rising edge with loadValid && loadReady, loadData SHALL be written at tail, and tail SHALL advance.
REQ-019 Arbitration: round-robin; the search starts at requester (lastWinner+1) mod NReq, and the first set req bit wins.
REQ-020 At most one requester SHALL be served per cycle; grant SHALL be a single-cycle pulse in the cycle after the winning edge, with latency 1.
REQ-021 A requester SHALL deassert req in the cycle grant is seen; a req still high on that edge is arbitrated again as a new request.
REQ-022 inSize served: data SHALL equal the pre-edge count zero-extended; hit=0; channel unchanged.
REQ-023 in served with count>0: data SHALL equal the head element; hit=1; head SHALL advance; count SHALL decrement.
REQ-024 in served with count==0: data=0; hit=0; no pointer or count change.
REQ-025 Load and a successful in on the same edge SHALL both occur; count unchanged; an in on an empty channel SHALL NOT return the same-edge load.
REQ-026 count SHALL never exceed NIn or underflow; loads while full are ignored with no state change.
REQ-027 With no req bit set, grant SHALL be 0 on the next cycle; data and hit SHALL hold their last values.
REQ-028 lastWinner SHALL update only on a grant.

Reset
REQ-029 While reset is high: grant=0, data=0, hit=0, count=0, head=tail=0, lastWinner=NReq-1 (requester 0 has first priority), loadReady=1.
REQ-030 Reset asserted mid-operation SHALL discard all stored elements and pending arbitration immediately, without waiting for a clock edge.
REQ-031 The first edge after reset release SHALL behave as normal arbitration; no request is remembered from before reset.

Verification
REQ-032 Load 88 then 44, requester 0 issues inSize, in, inSize, in, inSize -> data 2, 88 (hit=1), 1, 44 (hit=1), 0 (hit=0 throughout inSize).
REQ-033 Empty channel, requester 1 issues in -> grant=0b10, data=0, hit=0, count stays 0.
REQ-034 Both requesters hold in continuously with 4 elements loaded -> grants alternate 0b01, 0b10, 0b01, 0b10; data is returned in load order.
REQ-035 Load NIn elements -> loadReady=0; a further loadValid is ignored; one in plus loadValid on the same edge -> load rejected, count=NIn-1.
REQ-036 count=1, in and load 7 on the same edge -> old head returned with hit=1, count=1, next in returns 7.
REQ-037 Assert reset with count=3 and grant pending -> outputs clear asynchronously, count=0; first request after release goes to requester 0 if both request.

Source files
------------

// File: rtl/in_channel_arbiter_if.sv
// Handshake bundle for in_channel_arbiter: producer load port plus requester
// request/response lines. The master side drives requests and the slave side is the arbiter.
interface in_channel_arbiter_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 8,
  parameter int NReq               = 2
);
  localparam int CountWidth = $clog2(NIn + 1);

  logic                          loadValid;
  logic [MemoryElementWidth-1:0] loadData;
  logic                          loadReady;
  logic [NReq-1:0]               req;
  logic [NReq-1:0]               op;
  logic [NReq-1:0]               grant;
  logic [MemoryElementWidth-1:0] data;
  logic                          hit;
  logic [CountWidth-1:0]         count;

  modport master (
    output loadValid, loadData, req, op,
    input  loadReady, grant, data, hit, count
  );

  modport slave (
    input  loadValid, loadData, req, op,
    output loadReady, grant, data, hit, count
  );
endinterface

// File: rtl/in_channel_arbiter.sv
// Circular-buffer input channel shared by NReq requesters under round-robin
// arbitration; each grant answers either an inSize (occupancy) or an in (pop).
module in_channel_arbiter #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 8,
  parameter int NReq               = 2
) (
  input logic                clock,
  input logic                reset,
  in_channel_arbiter_if.slave bus
);
  localparam int CountWidth = $clog2(NIn + 1);
  localparam int PtrWidth   = (NIn > 1) ? $clog2(NIn) : 1;
  localparam int IdxWidth   = (NReq > 1) ? $clog2(NReq) : 1;

  logic [MemoryElementWidth-1:0] mem [NIn];
  logic [PtrWidth-1:0]           headR;
  logic [PtrWidth-1:0]           tailR;
  logic [CountWidth-1:0]         countR;
  logic [IdxWidth-1:0]           lastWinnerR;
  logic [NReq-1:0]               grantR;
  logic [MemoryElementWidth-1:0] dataR;
  logic                          hitR;

  logic                          anyReqS;
  logic [IdxWidth-1:0]           winnerS;
  logic                          doLoadS;
  logic                          doPopS;
  logic                          loadReadyS;
  logic [MemoryElementWidth-1:0] respDataS;

  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(NIn - 1)) begin
      return '0;
    end else begin
      return p + PtrWidth'(1);
    end
  endfunction

  assign loadReadyS = (countR < CountWidth'(NIn));
  assign doLoadS    = bus.loadValid && loadReadyS;

  // Round-robin search starting just after the last winner
  always_comb begin
    logic [IdxWidth-1:0] idx;
    idx     = '0;
    anyReqS = 1'b0;
    winnerS = '0;
    for (int i = 0; i < NReq; i++) begin
      idx = IdxWidth'((int'(lastWinnerR) + 1 + i) % NReq);
      if (!anyReqS && bus.req[idx]) begin
        anyReqS = 1'b1;
        winnerS = idx;
      end else begin
        anyReqS = anyReqS;
      end
    end
  end

  // Response selection for the winning requester's operation
  always_comb begin
    doPopS    = 1'b0;
    respDataS = '0;
    if (anyReqS && bus.op[winnerS]) begin
      if (countR != '0) begin
        doPopS    = 1'b1;
        respDataS = mem[headR];
      end else begin
        respDataS = '0;
      end
    end else begin
      respDataS = MemoryElementWidth'(countR);
    end
  end

  // Element storage; stale contents are never read past count, so no reset is needed
  always_ff @(posedge clock) begin
    if (doLoadS) begin
      mem[tailR] <= bus.loadData;
    end
  end

  // Pointers, occupancy, arbitration history and registered response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      headR       <= '0;
      tailR       <= '0;
      countR      <= '0;
      lastWinnerR <= IdxWidth'(NReq - 1);
      grantR      <= '0;
      dataR       <= '0;
      hitR        <= 1'b0;
    end else begin
      if (doLoadS) begin
        tailR <= nextPtr(tailR);
      end
      if (doPopS) begin
        headR <= nextPtr(headR);
      end
      case ({doLoadS, doPopS})
        2'b10:   countR <= countR + CountWidth'(1);
        2'b01:   countR <= countR - CountWidth'(1);
        default: countR <= countR;
      endcase
      if (anyReqS) begin
        grantR      <= NReq'(1'b1) << winnerS;
        lastWinnerR <= winnerS;
        dataR       <= respDataS;
        hitR        <= doPopS;
      end else begin
        grantR <= '0;
      end
    end
  end

  assign bus.loadReady = loadReadyS;
  assign bus.grant     = grantR;
  assign bus.data      = dataR;
  assign bus.hit       = hitR;
  assign bus.count     = countR;
endmodule

// File: tb/tb_in_channel_arbiter.sv
// Directed bench for in_channel_arbiter: expected grant responses are queued
// as stimulus is issued and a negedge monitor pops and compares them.
module tb_in_channel_arbiter;
  localparam int W    = 12;
  localparam int NIn  = 8;
  localparam int NReq = 2;

  typedef struct {
    logic [NReq-1:0] grant;
    logic [W-1:0]    data;
    logic            hit;
    logic [3:0]      count;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  in_channel_arbiter_if #(.MemoryElementWidth(W), .NIn(NIn), .NReq(NReq)) bus ();

  in_channel_arbiter #(.MemoryElementWidth(W), .NIn(NIn), .NReq(NReq)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_resp(input logic [NReq-1:0] g, input logic [W-1:0] d,
                             input logic h, input logic [3:0] c);
    exp_t e;
    e.grant = g; e.data = d; e.hit = h; e.count = c;
    sb.push_back(e);
  endtask

  task automatic load(input logic [W-1:0] d);
    bus.loadValid = 1'b1;
    bus.loadData  = d;
    tick();
    bus.loadValid = 1'b0;
  endtask

  // single requester r issues op o; request dropped once the grant edge passes
  task automatic issue(input int r, input logic o, input logic [W-1:0] d,
                       input logic h, input logic [3:0] c);
    logic [NReq-1:0] g;
    g = '0;
    g[r] = 1'b1;
    bus.req = g;
    bus.op  = o ? g : '0;
    expect_resp(g, d, h, c);
    tick();
    bus.req = '0;
    bus.op  = '0;
  endtask

  // monitor: every grant pulse must match the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && bus.grant != '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_grant: got %0d expected none", bus.grant);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("grant", 32'(bus.grant), 32'(e.grant));
        check("data",  32'(bus.data),  32'(e.data));
        check("hit",   32'(bus.hit),   32'(e.hit));
        check("count", 32'(bus.count), 32'(e.count));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.loadValid = 1'b0;
    bus.loadData  = '0;
    bus.req       = '0;
    bus.op        = '0;
    #2;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_data",  32'(bus.data),  32'd0);
    check("rst_hit",   32'(bus.hit),   32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ready", 32'(bus.loadReady), 32'd1);
    tick();
    tick();
    reset = 1'b0;

    // inSize / in sequence on a two-element channel
    load(12'd88);
    load(12'd44);
    check("count_two", 32'(bus.count), 32'd2);
    issue(0, 1'b0, 12'd2,  1'b0, 4'd2);
    issue(0, 1'b1, 12'd88, 1'b1, 4'd1);
    issue(0, 1'b0, 12'd1,  1'b0, 4'd1);
    issue(0, 1'b1, 12'd44, 1'b1, 4'd0);
    issue(0, 1'b0, 12'd0,  1'b0, 4'd0);

    // in on empty channel from requester 1
    issue(1, 1'b1, 12'd0, 1'b0, 4'd0);
    check("empty_count", 32'(bus.count), 32'd0);

    // both requesters hold in: alternating grants, load order preserved
    load(12'd10); load(12'd20); load(12'd30); load(12'd40);
    bus.req = 2'b11;
    bus.op  = 2'b11;
    expect_resp(2'b01, 12'd10, 1'b1, 4'd3);
    expect_resp(2'b10, 12'd20, 1'b1, 4'd2);
    expect_resp(2'b01, 12'd30, 1'b1, 4'd1);
    expect_resp(2'b10, 12'd40, 1'b1, 4'd0);
    repeat (4) tick();
    bus.req = '0;
    bus.op  = '0;
    tick();
    check("idle_grant", 32'(bus.grant), 32'd0);
    check("idle_data",  32'(bus.data),  32'd40);
    check("idle_hit",   32'(bus.hit),   32'd1);

    // fill, overflow attempt, then pop with a rejected same-edge load
    for (int i = 0; i < NIn; i++) load(W'(100 + i));
    check("full_count", 32'(bus.count), 32'd8);
    check("full_ready", 32'(bus.loadReady), 32'd0);
    load(12'd999);
    check("full_ignored", 32'(bus.count), 32'd8);
    bus.loadValid = 1'b1;
    bus.loadData  = 12'd555;
    issue(0, 1'b1, 12'd100, 1'b1, 4'd7);
    bus.loadValid = 1'b0;
    check("full_pop_count", 32'(bus.count), 32'd7);
    for (int i = 1; i < NIn; i++) issue(0, 1'b1, W'(100 + i), 1'b1, 4'(NIn - 1 - i));

    // same-edge load and pop at count 1
    load(12'd5);
    bus.loadValid = 1'b1;
    bus.loadData  = 12'd7;
    issue(0, 1'b1, 12'd5, 1'b1, 4'd1);
    bus.loadValid = 1'b0;
    check("ldpop_count", 32'(bus.count), 32'd1);
    issue(0, 1'b1, 12'd7, 1'b1, 4'd0);

    // asynchronous reset with elements stored and a grant on the outputs
    load(12'd1); load(12'd2); load(12'd3);
    bus.req = 2'b01;
    bus.op  = 2'b00;
    expect_resp(2'b01, 12'd3, 1'b0, 4'd3);
    tick();
    bus.req = 2'b11;
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("arst_grant", 32'(bus.grant), 32'd0);
    check("arst_data",  32'(bus.data),  32'd0);
    check("arst_hit",   32'(bus.hit),   32'd0);
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_ready", 32'(bus.loadReady), 32'd1);
    tick();
    reset = 1'b0;
    expect_resp(2'b01, 12'd0, 1'b0, 4'd0);
    tick();
    bus.req = '0;
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
